addressable_shift_buffer: RTL and testbench
===========================================

# addressable_shift_buffer

Parametrised, addressable shift-history buffer for the UART datapath. Each push shifts a new word into slot 0 and ages existing words by one slot. Any slot can be read by age index with one-cycle registered latency, and the oldest word can be retired by pop. Occupancy tracking, full/empty status and overflow/underflow pulses replace the fixed 32×32 shift store of the previous generation.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 32, number of slots (≥2)
- AW, $clog2(DEPTH), address/index width (derived, not overridden)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- push  input  1  shift din into slot 0 this cycle
- din  input  WIDTH  data to push
- pop  input  1  retire oldest valid entry (slot count-1)
- addr  input  AW  age index to read (0 = newest)
- dout  output  WIDTH  registered read data
- dout_valid  output  1  registered: addressed slot held a valid entry
- count  output  AW+1  number of valid entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  one-cycle pulse: push accepted while full, oldest entry discarded
- underflow  output  1  one-cycle pulse: pop requested while empty

## Operation
- Storage data[0..DEPTH-1]. Slot 0 is the newest entry; slot count-1 is the oldest valid entry.
- Push: data[i] ← data[i-1] for i = DEPTH-1..1, and data[0] ← din. The word in data[DEPTH-1] is lost.
- Pop alone, count > 0: count ← count-1. Stored data does not move.
- Count update rules:
  - push only, not full: count+1
  - push only, full: count stays DEPTH; overflow pulses
  - push+pop, count > 0: count unchanged (the shift ages the data; the oldest entry is retired)
  - push+pop, count == 0: count ← 1; underflow pulses
  - pop only, empty: no change; underflow pulses
- Read is write-through. dout is the value slot addr holds after this cycle's update: din if push and addr == 0; data[addr-1] if push and addr > 0; otherwise data[addr].
- dout_valid ← (addr < next count) and (addr < DEPTH).
- addr ≥ DEPTH (non-power-of-2 DEPTH only): dout ← 0, dout_valid ← 0.
- full and empty are combinational from the count register.

## Timing
- Reset (rst high at an edge): all data slots ← 0, dout ← 0, dout_valid ← 0, count ← 0, overflow ← 0, underflow ← 0. Hence full = 0 and empty = 1.
- Reset overrides push and pop in the same cycle. Reset may be asserted mid-stream; contents are discarded.
- Read latency is 1 cycle: addr and push/pop sampled at edge N yield dout/dout_valid after edge N, reflecting the post-edge-N state.
- count, full and empty update at the same edge as the push/pop that changes them.
- overflow and underflow are registered and high for exactly the one cycle following the offending edge.
- There is no back-pressure: push is always accepted and pop is never stalled.

## Configuration
- ADDR_SHIFT_BUF_CLEAR_ON_POP_EN defined:
  - on pop with count > 0, slot count-1 is written to 0 (on push+pop, the slot at index count after the shift is zeroed)
  - reads of invalid slots return dout = 0
- Undefined:
  - popped slots retain stale data
  - reads of invalid slots return the stale contents, with dout_valid = 0
- count, flags and timing are identical in both builds.

## Test plan
- Reset, then push 0xA1, 0xA2, 0xA3 on consecutive cycles; read addr 0, 1, 2 → dout 0xA3, 0xA2, 0xA1 with dout_valid 1; count = 3.
- Push and read addr 0 in the same cycle with din = 0x55 → dout 0x55 on the next cycle (write-through).
- Push DEPTH+1 words 1..33 (DEPTH = 32) → overflow pulses once on the last push; count = 32; full = 1; addr 31 reads 2.
- With count = 3, assert push 0x77 + pop together → count stays 3; addr 0 reads 0x77; addr 3 reads dout_valid 0 (dout 0 with the macro defined, stale data without).
- Pop when empty → underflow for one cycle; count = 0; empty stays 1. Then pop 3 times after 3 pushes → empty = 1.
- Assert rst mid-stream with push high → next cycle count = 0, dout = 0, dout_valid = 0; addr 0 reads 0.

Source files
------------

// File: rtl/addressable_shift_buffer.sv
// addressable_shift_buffer
//   Shift-history buffer. A push shifts din into slot 0 and ages every stored
//   word by one slot. A pop retires the oldest valid word (slot count-1). Any
//   slot can be read by age index with one cycle of registered latency. The
//   read is write-through: it returns what the slot holds after this cycle's
//   push/pop.
//
//   Optional feature macro: ADDR_SHIFT_BUF_CLEAR_ON_POP_EN
//     defined   - a popped slot is zeroed, and reads of invalid slots return 0
//     undefined - popped slots keep stale data, and invalid reads return it
//                 with dout_valid low
//
//   Handshake: there is no valid/ready pair. push and pop are single-cycle
//   strobes, sampled at each rising edge and always accepted with no stall.
//   Misuse is flagged by one-cycle pulses: overflow (push while full, oldest
//   word dropped) and underflow (pop while empty).
module addressable_shift_buffer #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full_w;
    logic             empty_w;
    logic             addr_in_range;

    // Status comes straight from the count register.
    assign full_w        = (count_q == DEPTH_C);
    assign empty_w       = (count_q == '0);
    // Only reachable with a non-power-of-two DEPTH.
    assign addr_in_range = ({1'b0, addr} < DEPTH_C);

`ifdef ADDR_SHIFT_BUF_CLEAR_ON_POP_EN
    // Index of the oldest valid slot; only meaningful while count > 0.
    logic [AW-1:0] oldest_slot;
    assign oldest_slot = count_q[AW-1:0] - 1'b1;
`endif

    // Occupancy update and misuse pulses.
    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (push && pop) begin
            // The shift ages the data and the pop retires the oldest entry.
            if (empty_w) begin
                count_d     = (AW+1)'(1);
                underflow_d = 1'b1;
            end
        end else if (push) begin
            if (full_w) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            if (empty_w) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Storage update: shift on push, optionally clear the retired slot.
    always_comb begin
        data_d = data_q;
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                data_d[i] = data_q[i-1];
            end
            data_d[0] = din;
        end
`ifdef ADDR_SHIFT_BUF_CLEAR_ON_POP_EN
        if (pop && !empty_w) begin
            if (push) begin
                // After the shift the retired word sits at index count; when
                // full it has already fallen off the end.
                if (!full_w) begin
                    data_d[count_q[AW-1:0]] = '0;
                end
            end else begin
                data_d[oldest_slot] = '0;
            end
        end
`endif
    end

    // Write-through read of the post-update state.
    always_comb begin
        dout_valid_d = addr_in_range && ({1'b0, addr} < count_d);
        dout_d       = '0;
        if (addr_in_range) begin
            dout_d = data_d[addr];
        end
`ifdef ADDR_SHIFT_BUF_CLEAR_ON_POP_EN
        if (!dout_valid_d) begin
            dout_d = '0;
        end
`endif
    end

    // State registers with synchronous reset that overrides push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            data_q       <= data_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_addressable_shift_buffer.sv
// tb_addressable_shift_buffer
//   Directed steps followed by random push/pop/read traffic, compared every
//   cycle against a queue-based history model of the buffer.
module tb_addressable_shift_buffer;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    // Clock and reset
    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [W-1:0]  din;
    logic          pop;
    logic [AW-1:0] addr;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    addressable_shift_buffer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .din        (din),
        .pop        (pop),
        .addr       (addr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: hist[k] is the word of age k (0 = newest), always
    // DEPTH entries long; cnt is how many of them are valid.
    logic [W-1:0] hist [$];
    int           cnt;
    logic [W-1:0] exp_dout;
    logic         exp_valid;
    logic         exp_ovf;
    logic         exp_udf;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('0);
        cnt       = 0;
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit p, input bit q,
                              input logic [W-1:0] d, input int a);
        if (r) begin
            model_reset();
            return;
        end
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        if (p) begin
            hist.push_front(d);
            void'(hist.pop_back());
        end
        if (p && q) begin
            if (cnt == 0) begin
                cnt     = 1;
                exp_udf = 1'b1;
            end else begin
`ifdef ADDR_SHIFT_BUF_CLEAR_ON_POP_EN
                if (cnt < DEPTH) hist[cnt] = '0;
`endif
            end
        end else if (p) begin
            if (cnt == DEPTH) exp_ovf = 1'b1;
            else cnt++;
        end else if (q) begin
            if (cnt == 0) exp_udf = 1'b1;
            else begin
                cnt--;
`ifdef ADDR_SHIFT_BUF_CLEAR_ON_POP_EN
                hist[cnt] = '0;
`endif
            end
        end
        exp_valid = (a < cnt);
        exp_dout  = hist[a];
`ifdef ADDR_SHIFT_BUF_CLEAR_ON_POP_EN
        if (!exp_valid) exp_dout = '0;
`endif
    endtask

    // Scoreboard comparison
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"},       64'(dout),       64'(exp_dout));
        chk({tag, ".dout_valid"}, 64'(dout_valid), 64'(exp_valid));
        chk({tag, ".count"},      64'(count),      64'(cnt));
        chk({tag, ".full"},       64'(full),       64'(cnt == DEPTH));
        chk({tag, ".empty"},      64'(empty),      64'(cnt == 0));
        chk({tag, ".overflow"},   64'(overflow),   64'(exp_ovf));
        chk({tag, ".underflow"},  64'(underflow),  64'(exp_udf));
    endtask

    // Driver: one clock cycle of stimulus, model update, then output check.
    task automatic step(input bit r, input bit p, input bit q,
                        input logic [W-1:0] d, input int a, input string tag);
        rst  = r;
        push = p;
        pop  = q;
        din  = d;
        addr = a[AW-1:0];
        @(posedge clk);
        model_step(r, p, q, d, a);
        #1;
        check_all(tag);
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;
        addr = '0;
        model_reset();

        // Reset state
        step(1, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, "idle");

        // Three pushes then reads by age
        step(0, 1, 0, 32'hA1, 0, "push_a1");
        step(0, 1, 0, 32'hA2, 0, "push_a2");
        step(0, 1, 0, 32'hA3, 0, "push_a3");
        step(0, 0, 0, 0, 0, "rd0");
        chk("plan_rd0", 64'(dout), 64'hA3);
        step(0, 0, 0, 0, 1, "rd1");
        chk("plan_rd1", 64'(dout), 64'hA2);
        step(0, 0, 0, 0, 2, "rd2");
        chk("plan_rd2", 64'(dout), 64'hA1);
        chk("plan_cnt3", 64'(count), 64'd3);

        // Write-through read of the newest slot
        step(0, 1, 0, 32'h55, 0, "wt55");
        chk("plan_wt55", 64'(dout), 64'h55);

        // Fill past capacity
        step(1, 0, 0, 0, 0, "reset_fill");
        for (int v = 1; v <= DEPTH + 1; v++) step(0, 1, 0, W'(v), 31, "fill");
        chk("plan_ovf", 64'(overflow), 64'd1);
        chk("plan_full", 64'(full), 64'd1);
        step(0, 0, 0, 0, 31, "rd31");
        chk("plan_rd31", 64'(dout), 64'd2);
        chk("plan_ovf_drop", 64'(overflow), 64'd0);

        // Simultaneous push and pop with three entries
        step(1, 0, 0, 0, 0, "reset_pp");
        step(0, 1, 0, 32'h11, 0, "pp_a");
        step(0, 1, 0, 32'h22, 0, "pp_b");
        step(0, 1, 0, 32'h33, 0, "pp_c");
        step(0, 1, 1, 32'h77, 0, "pp_both");
        chk("plan_pp_dout", 64'(dout), 64'h77);
        chk("plan_pp_cnt", 64'(count), 64'd3);
        step(0, 0, 0, 0, 3, "pp_rd3");
        chk("plan_pp_v3", 64'(dout_valid), 64'd0);

        // Underflow, then drain
        step(1, 0, 0, 0, 0, "reset_udf");
        step(0, 0, 1, 0, 0, "udf");
        chk("plan_udf", 64'(underflow), 64'd1);
        step(0, 0, 0, 0, 0, "udf_drop");
        chk("plan_udf_drop", 64'(underflow), 64'd0);
        step(0, 1, 1, 32'hC0, 0, "pp_empty");
        step(0, 0, 1, 0, 0, "pop_one");
        for (int k = 0; k < 3; k++) step(0, 1, 0, W'(32'hD0 + k), k, "drain_push");
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, "drain_pop");
        chk("plan_drained", 64'(empty), 64'd1);

        // Reset mid-stream with push asserted
        step(0, 1, 0, 32'hE1, 0, "mid_push");
        step(1, 1, 0, 32'hE2, 0, "mid_rst");
        chk("plan_mid_cnt", 64'(count), 64'd0);
        step(0, 0, 0, 0, 0, "mid_rd0");
        chk("plan_mid_dout", 64'(dout), 64'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, p, q;
            r = ($urandom_range(0, 199) == 0);
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 35);
            step(r, p, q, $urandom, int'($urandom_range(0, DEPTH - 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
